// File: rtl/atadev_pkg.sv
// Shared types and constants for the ATA device-side PIO responder.
// State encoding plus PIO mode-0 default timings in 100 MHz clk ticks.
package atadev_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_DRIVE,
    RD_HOLD,
    WR_ACTIVE
  } state_e;

  localparam int ADDR_W = 5;

  localparam int PIO0_TRD   = 0;
  localparam int PIO0_T6    = 1;
  localparam int PIO0_TBMAX = 125;

endpackage

// File: rtl/atadev_sync_edge.sv
// N-stage synchroniser for an asynchronous level, with rise/fall pulses.
// The pulses are valid in the cycle where the synchronised level first differs from its previous sample.
module atadev_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/atadev_pio_tctrl.sv
// ATA device-side PIO responder: decodes host DIOR-/DIOW- strobes, fetches/commits
// task-file data through a request/ack register port and throttles the host with IORDY.
module atadev_pio_tctrl
  import atadev_pkg::*;
#(
  parameter int TWIDTH      = 8,
  parameter int DWIDTH      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IORDY_en,
  input  logic [TWIDTH-1:0] Trd,
  input  logic [TWIDTH-1:0] T6,
  input  logic [TWIDTH-1:0] Tbmax,
  input  logic              DIOR,
  input  logic              DIOW,
  input  logic              CS0,
  input  logic              CS1,
  input  logic [2:0]        DA,
  input  logic [DWIDTH-1:0] DDi,
  output logic [DWIDTH-1:0] DDo,
  output logic              DDoe,
  output logic              IORDY,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              wr_stb,
  output logic [DWIDTH-1:0] wr_data,
  input  logic              wr_busy,
  output logic              err
);

  localparam logic [TWIDTH-1:0] CNT_ONE = TWIDTH'(1);

  logic dior_s, dior_rise, dior_fall;
  logic diow_s, diow_rise, diow_fall;

  atadev_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dior (
    .clk     (clk),
    .rst     (rst),
    .async_i (DIOR),
    .sync_o  (dior_s),
    .rise_o  (dior_rise),
    .fall_o  (dior_fall)
  );

  atadev_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_diow (
    .clk     (clk),
    .rst     (rst),
    .async_i (DIOW),
    .sync_o  (diow_s),
    .rise_o  (diow_rise),
    .fall_o  (diow_fall)
  );

  // DDi delayed to line up with the synchronised strobes; ddi_last_q matches the
  // strobe's previous sample, i.e. the last high DIOW sample when a fall is seen.
  logic [DWIDTH-1:0] ddi_pipe_q [SYNC_STAGES];
  logic [DWIDTH-1:0] ddi_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) ddi_pipe_q[i] <= '0;
      ddi_last_q <= '0;
    end else begin
      ddi_pipe_q[0] <= DDi;
      for (int i = 1; i < SYNC_STAGES; i++) ddi_pipe_q[i] <= ddi_pipe_q[i-1];
      ddi_last_q <= ddi_pipe_q[SYNC_STAGES-1];
    end
  end

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] ddo_q, ddo_d;
  logic              ddoe_q, ddoe_d;
  logic              iordy_q, iordy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_stb_q, wr_stb_d;
  logic [DWIDTH-1:0] wr_data_q, wr_data_d;
  logic              wr_pend_q, wr_pend_d;
  logic              err_q, err_d;
  logic [TWIDTH-1:0] trd_q, trd_d;
  logic [TWIDTH-1:0] t6_q, t6_d;
  logic [TWIDTH-1:0] tb_q, tb_d;
  logic              tb_exp_q, tb_exp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ddo_q     <= '0;
      ddoe_q    <= 1'b0;
      iordy_q   <= 1'b1;
      addr_q    <= '0;
      rd_req_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_data_q <= '0;
      wr_pend_q <= 1'b0;
      err_q     <= 1'b0;
      trd_q     <= '0;
      t6_q      <= '0;
      tb_q      <= '0;
      tb_exp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ddo_q     <= ddo_d;
      ddoe_q    <= ddoe_d;
      iordy_q   <= iordy_d;
      addr_q    <= addr_d;
      rd_req_q  <= rd_req_d;
      wr_stb_q  <= wr_stb_d;
      wr_data_q <= wr_data_d;
      wr_pend_q <= wr_pend_d;
      err_q     <= err_d;
      trd_q     <= trd_d;
      t6_q      <= t6_d;
      tb_q      <= tb_d;
      tb_exp_q  <= tb_exp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ddo_d     = ddo_q;
    ddoe_d    = ddoe_q;
    iordy_d   = iordy_q;
    addr_d    = addr_q;
    rd_req_d  = rd_req_q;
    wr_stb_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_pend_d = wr_pend_q;
    err_d     = 1'b0;
    trd_d     = trd_q;
    t6_d      = t6_q;
    tb_d      = tb_q;
    tb_exp_d  = tb_exp_q;

    case (state_q)
      IDLE: begin
        iordy_d = 1'b1;
        if ((dior_rise || diow_rise) && dior_s && diow_s) begin
          err_d = 1'b1;
        end else if (dior_rise) begin
          state_d  = RD_FETCH;
          rd_req_d = 1'b1;
          iordy_d  = 1'b0;
          addr_d   = {CS1, CS0, DA};
        end else if (diow_rise) begin
          state_d = WR_ACTIVE;
          addr_d  = {CS1, CS0, DA};
        end
      end

      RD_FETCH: begin
        if (diow_rise) err_d = 1'b1;
        if (rd_ack) begin
          ddo_d    = rd_data;
          ddoe_d   = 1'b1;
          rd_req_d = 1'b0;
          trd_d    = Trd;
          state_d  = RD_DRIVE;
        end
      end

      RD_DRIVE: begin
        if (diow_rise) err_d = 1'b1;
        // Release lands on the edge where the counter reaches zero.
        if (trd_q <= CNT_ONE) iordy_d = 1'b1;
        if (trd_q != '0) trd_d = trd_q - CNT_ONE;
        // Level check also covers a host that dropped DIOR while we were still fetching.
        if (dior_fall || !dior_s) begin
          t6_d    = T6;
          iordy_d = 1'b1;
          state_d = RD_HOLD;
        end
      end

      RD_HOLD: begin
        iordy_d = 1'b1;
        if (dior_rise || diow_rise) err_d = 1'b1;
        if (t6_q <= CNT_ONE) begin
          ddoe_d  = 1'b0;
          state_d = IDLE;
        end
        if (t6_q != '0) t6_d = t6_q - CNT_ONE;
      end

      WR_ACTIVE: begin
        iordy_d = !wr_busy;
        if (dior_rise || (wr_pend_q && diow_rise)) err_d = 1'b1;
        if (wr_pend_q) begin
          if (!wr_busy) begin
            wr_stb_d  = 1'b1;
            wr_pend_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (diow_fall) begin
          wr_data_d = ddi_last_q;
          if (!wr_busy) begin
            wr_stb_d = 1'b1;
            state_d  = IDLE;
          end else begin
            wr_pend_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (!IORDY_en || tb_exp_q) iordy_d = 1'b1;

    // IORDY hold-off watchdog: armed on the falling edge of IORDY, Tbmax=0 never arms it.
    if (iordy_q && !iordy_d) begin
      tb_d = Tbmax;
    end else if (!iordy_q && tb_q != '0) begin
      tb_d = tb_q - CNT_ONE;
      if (tb_q == CNT_ONE && !iordy_d) begin
        iordy_d  = 1'b1;
        err_d    = 1'b1;
        tb_exp_d = 1'b1;
      end
    end

    if (state_d == IDLE) tb_exp_d = 1'b0;
  end

  assign DDo     = ddo_q;
  assign DDoe    = ddoe_q;
  assign IORDY   = iordy_q;
  assign addr    = addr_q;
  assign rd_req  = rd_req_q;
  assign wr_stb  = wr_stb_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_atadev_pio_tctrl.sv
// Directed bench for atadev_pio_tctrl: read, write, busy write, IORDY timeout,
// strobe collision and mid-transfer reset, each with hand-computed expectations.
module tb_atadev_pio_tctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        IORDY_en;
  logic [7:0]  Trd, T6, Tbmax;
  logic        DIOR, DIOW, CS0, CS1;
  logic [2:0]  DA;
  logic [15:0] DDi, DDo, rd_data, wr_data;
  logic        DDoe, IORDY, rd_req, rd_ack, wr_stb, wr_busy, err;
  logic [4:0]  addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atadev_pio_tctrl dut (
    .clk      (clk),
    .rst      (rst),
    .IORDY_en (IORDY_en),
    .Trd      (Trd),
    .T6       (T6),
    .Tbmax    (Tbmax),
    .DIOR     (DIOR),
    .DIOW     (DIOW),
    .CS0      (CS0),
    .CS1      (CS1),
    .DA       (DA),
    .DDi      (DDi),
    .DDo      (DDo),
    .DDoe     (DDoe),
    .IORDY    (IORDY),
    .addr     (addr),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .wr_stb   (wr_stb),
    .wr_data  (wr_data),
    .wr_busy  (wr_busy),
    .err      (err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rd_req(input string name);
    int n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!rd_req) begin
      errors++;
      $display("FAIL %s rd_req timeout got %b want 1", name, rd_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; IORDY_en = 1'b1; Trd = 8'd0; T6 = 8'd1; Tbmax = 8'd125;
    DIOR = 0; DIOW = 0; CS0 = 0; CS1 = 0; DA = 3'd0; DDi = 16'h0;
    rd_ack = 0; rd_data = 16'h0; wr_busy = 0;
    tick(2);
    checks++;
    if ({DDo, DDoe, IORDY, addr, rd_req, wr_stb, wr_data, err} !== {16'h0, 1'b0, 1'b1, 5'h0, 1'b0, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got DDo=%h DDoe=%b IORDY=%b addr=%h rd_req=%b wr_stb=%b wr_data=%h err=%b want 0/0/1/0/0/0/0/0",
               DDo, DDoe, IORDY, addr, rd_req, wr_stb, wr_data, err);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_read();
    int low_bad = 0;
    Trd = 8'd3; T6 = 8'd2; Tbmax = 8'd125;
    CS1 = 0; CS0 = 1; DA = 3'd7; DIOR = 1;
    wait_rd_req("read");
    checks++;
    if (addr !== 5'h0F) begin errors++; $display("FAIL read_addr got %h want 0f", addr); end
    for (int i = 0; i < 4; i++) begin
      if (IORDY !== 1'b0) low_bad++;
      if (i < 3) tick();
    end
    rd_ack = 1; rd_data = 16'hA5C3;
    tick();
    rd_ack = 0; rd_data = 16'h0;
    checks++;
    if ({DDoe, DDo, rd_req, IORDY} !== {1'b1, 16'hA5C3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_drive got DDoe=%b DDo=%h rd_req=%b IORDY=%b want 1 a5c3 0 0", DDoe, DDo, rd_req, IORDY);
    end
    tick(); if (IORDY !== 1'b0) low_bad++;
    tick(); if (IORDY !== 1'b0) low_bad++;
    checks++;
    if (low_bad != 0) begin errors++; $display("FAIL read_iordy_low got %0d early releases want 0", low_bad); end
    tick();
    checks++;
    if (IORDY !== 1'b1) begin errors++; $display("FAIL read_iordy_release got %b want 1", IORDY); end
    DIOR = 0;
    tick(4);
    checks++;
    if (DDoe !== 1'b1) begin errors++; $display("FAIL read_t6_hold got DDoe=%b want 1", DDoe); end
    tick();
    checks++;
    if ({DDoe, DDo} !== {1'b0, 16'hA5C3}) begin
      errors++;
      $display("FAIL read_t6_end got DDoe=%b DDo=%h want 0 a5c3", DDoe, DDo);
    end
    tick(3);
  endtask

  task automatic test_write();
    int stb_n = 0, iordy_low = 0;
    logic [15:0] cap = 16'h0;
    CS1 = 0; CS0 = 1; DA = 3'd0; DDi = 16'h1234; DIOW = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (IORDY !== 1'b1) iordy_low++;
    end
    DIOW = 0; DDi = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (IORDY !== 1'b1) iordy_low++;
      if (wr_stb === 1'b1) begin stb_n++; cap = wr_data; end
    end
    checks++;
    if (stb_n != 1) begin errors++; $display("FAIL write_stb_count got %0d want 1", stb_n); end
    checks++;
    if (cap !== 16'h1234) begin errors++; $display("FAIL write_data got %h want 1234", cap); end
    checks++;
    if (iordy_low != 0) begin errors++; $display("FAIL write_iordy got %0d low cycles want 0", iordy_low); end
    checks++;
    if (addr !== 5'h08) begin errors++; $display("FAIL write_addr got %h want 08", addr); end
  endtask

  task automatic test_write_busy();
    int stb_n = 0;
    wr_busy = 1; DDi = 16'hBEEF; DIOW = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) begin DIOW = 0; DDi = 16'h0000; end
      if (wr_stb === 1'b1) stb_n++;
      if (i == 10 || i == 19) begin
        checks++;
        if (IORDY !== 1'b0) begin errors++; $display("FAIL busy_iordy cycle %0d got %b want 0", i, IORDY); end
      end
    end
    checks++;
    if (stb_n != 0) begin errors++; $display("FAIL busy_early_stb got %0d want 0", stb_n); end
    wr_busy = 0;
    tick();
    checks++;
    if ({wr_stb, wr_data, IORDY} !== {1'b1, 16'hBEEF, 1'b1}) begin
      errors++;
      $display("FAIL busy_commit got wr_stb=%b wr_data=%h IORDY=%b want 1 beef 1", wr_stb, wr_data, IORDY);
    end
    tick();
    checks++;
    if (wr_stb !== 1'b0) begin errors++; $display("FAIL busy_stb_single got %b want 0", wr_stb); end
    tick(3);
  endtask

  task automatic test_timeout();
    int err_n = 0, oe_seen = 0;
    Tbmax = 8'd8; T6 = 8'd2; DIOR = 1;
    wait_rd_req("timeout");
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (err === 1'b1) err_n++;
      if (DDoe !== 1'b0) oe_seen++;
      if (k == 7) begin
        checks++;
        if (IORDY !== 1'b0) begin errors++; $display("FAIL tmo_before got IORDY=%b want 0", IORDY); end
      end
      if (k == 8) begin
        checks++;
        if ({IORDY, err} !== 2'b11) begin errors++; $display("FAIL tmo_expire got IORDY=%b err=%b want 1 1", IORDY, err); end
      end
    end
    checks++;
    if (err_n != 1) begin errors++; $display("FAIL tmo_err_count got %0d want 1", err_n); end
    checks++;
    if ({oe_seen != 0, rd_req} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_state got DDoe_cycles=%0d rd_req=%b want 0 1", oe_seen, rd_req);
    end
    DIOR = 0;
    tick(4);
    rd_ack = 1; rd_data = 16'h1111;
    tick();
    rd_ack = 0;
    tick(8);
    checks++;
    if ({DDoe, rd_req, IORDY} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_recover got DDoe=%b rd_req=%b IORDY=%b want 0 0 1", DDoe, rd_req, IORDY);
    end
    Tbmax = 8'd125;
  endtask

  task automatic test_both_strobes();
    int err_n = 0, req_n = 0, stb_n = 0, low_n = 0;
    DIOR = 1; DIOW = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (err === 1'b1) err_n++;
      if (rd_req === 1'b1) req_n++;
      if (wr_stb === 1'b1) stb_n++;
      if (IORDY !== 1'b1) low_n++;
    end
    checks++;
    if (err_n != 1) begin errors++; $display("FAIL both_err got %0d want 1", err_n); end
    checks++;
    if (req_n + stb_n + low_n != 0) begin
      errors++;
      $display("FAIL both_quiet got rd_req=%0d wr_stb=%0d iordy_low=%0d want 0 0 0", req_n, stb_n, low_n);
    end
    DIOR = 0; DIOW = 0;
    tick(4);
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    Trd = 8'd20; T6 = 8'd2; CS1 = 0; CS0 = 1; DA = 3'd5; DIOR = 1;
    wait_rd_req("rst_first");
    rd_ack = 1; rd_data = 16'hC0DE;
    tick();
    rd_ack = 0;
    tick(2);
    #2;
    rst = 1; DIOR = 0;
    #1;
    checks++;
    if ({DDo, DDoe, IORDY, addr, rd_req, err} !== {16'h0, 1'b0, 1'b1, 5'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async got DDo=%h DDoe=%b IORDY=%b addr=%h rd_req=%b err=%b want 0 0 1 0 0 0",
               DDo, DDoe, IORDY, addr, rd_req, err);
    end
    tick();
    rst = 0;
    tick(3);
    Trd = 8'd0; T6 = 8'd1; CS1 = 1; CS0 = 0; DA = 3'd2; DIOR = 1;
    wait_rd_req("rst_second");
    checks++;
    if ({addr, IORDY} !== {5'h12, 1'b0}) begin errors++; $display("FAIL rst_read_addr got addr=%h IORDY=%b want 12 0", addr, IORDY); end
    tick(2);
    rd_ack = 1; rd_data = 16'h5A5A;
    tick();
    rd_ack = 0;
    checks++;
    if ({DDoe, DDo, IORDY} !== {1'b1, 16'h5A5A, 1'b0}) begin
      errors++;
      $display("FAIL rst_read_drive got DDoe=%b DDo=%h IORDY=%b want 1 5a5a 0", DDoe, DDo, IORDY);
    end
    tick();
    checks++;
    if (IORDY !== 1'b1) begin errors++; $display("FAIL rst_read_release got %b want 1", IORDY); end
    DIOR = 0;
    while (DDoe && n < 12) begin tick(); n++; end
    checks++;
    if ({DDoe, DDo} !== {1'b0, 16'h5A5A}) begin
      errors++;
      $display("FAIL rst_read_end got DDoe=%b DDo=%h want 0 5a5a", DDoe, DDo);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_write_busy();
    test_timeout();
    test_both_strobes();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
